// File: rtl/c3lib_rr_arb_lock.sv
// Purpose : round-robin arbiter with burst lock merging NUM_REQ valid/ready requesters onto one channel.
// Latency : 1 cycle arbitration (IDLE -> BUSY), then a combinational datapath from the owner to the channel.
// Backpress: out_rdy=0 stalls the owner (no gnt, beat count and state hold); other requesters wait for release.
//
// Ports:
//   clk, rst           block clock, asynchronous active-high reset
//   req/req_data/req_last  per-requester valid, data (requester i at [i*DWIDTH +: DWIDTH]), end-of-burst
//   gnt                per-requester accept, high when that requester's beat is consumed this cycle
//   out_vld/out_data/out_last/out_rdy  merged downstream channel
//   owner_idx, busy    registered ownership status
//   any_req            combinational OR of all req bits (valid during reset)
module c3lib_rr_arb_lock #(
    parameter int NUM_REQ   = 4,
    parameter int DWIDTH    = 8,
    parameter int MAX_BEATS = 16,
    parameter int IDXW      = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DWIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      out_vld,
    output logic [DWIDTH-1:0]         out_data,
    output logic                      out_last,
    input  logic                      out_rdy,
    output logic [IDXW-1:0]           owner_idx,
    output logic                      busy,
    output logic                      any_req
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [7:0]      LP_MAX_BEATS = 8'(MAX_BEATS);
    localparam logic [IDXW-1:0] LP_LAST_IDX  = IDXW'(NUM_REQ - 1);
    localparam logic [IDXW:0]   LP_NUM_REQ   = (IDXW + 1)'(NUM_REQ);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDXW-1:0]   r_owner;
    logic [IDXW-1:0]   w_owner_nxt;
    logic [IDXW-1:0]   r_rr_ptr;
    logic [IDXW-1:0]   w_rr_ptr_nxt;
    logic [7:0]        r_beat_cnt;
    logic [7:0]        w_beat_cnt_nxt;

    logic              w_found;
    logic [IDXW-1:0]   w_winner;
    logic [IDXW:0]     w_scan;
    logic              w_accept;
    logic              w_release;
    logic [DWIDTH-1:0] w_req_data [NUM_REQ];

    assign any_req   = |req;
    assign owner_idx = r_owner;
    assign busy      = (r_state == ST_BUSY);

    // Unpack the flat data bus so the owner mux is a plain array index.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_req_data[i] = req_data[i*DWIDTH +: DWIDTH];
        end
    end

    // Scan upward from rr_ptr with wrap; the first set req bit wins.
    // The wrapped index is computed one bit wider so the subtract-on-overflow
    // also works when NUM_REQ is not a power of two.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_scan   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan = {1'b0, r_rr_ptr} + (IDXW + 1)'(k);
            if (w_scan >= LP_NUM_REQ) begin
                w_scan = w_scan - LP_NUM_REQ;
            end
            if (!w_found && req[w_scan[IDXW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_scan[IDXW-1:0];
            end
        end
    end

    // Next-state and channel outputs.
    always_comb begin
        w_state_nxt    = r_state;
        w_owner_nxt    = r_owner;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_beat_cnt_nxt = r_beat_cnt;
        gnt            = '0;
        out_vld        = 1'b0;
        out_data       = '0;
        out_last       = 1'b0;
        w_accept       = 1'b0;
        w_release      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // No beat is ever accepted here; ownership starts next cycle.
                if (w_found) begin
                    w_state_nxt    = ST_BUSY;
                    w_owner_nxt    = w_winner;
                    w_beat_cnt_nxt = '0;
                end
            end
            ST_BUSY: begin
                out_vld      = req[r_owner];
                out_data     = w_req_data[r_owner];
                out_last     = req_last[r_owner];
                w_accept     = req[r_owner] & out_rdy;
                gnt[r_owner] = w_accept;
                if (w_accept) begin
                    if (r_beat_cnt != LP_MAX_BEATS) begin
                        w_beat_cnt_nxt = r_beat_cnt + 8'd1;
                    end
                    // This beat is the MAX_BEATS-th one when the count is one short.
                    w_release = out_last || (r_beat_cnt >= (LP_MAX_BEATS - 8'd1));
                end
                if (w_release) begin
                    w_state_nxt  = ST_IDLE;
                    w_rr_ptr_nxt = (r_owner == LP_LAST_IDX) ? '0 : r_owner + IDXW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_c3lib_rr_arb_lock.sv
// Purpose : directed self-checking bench for c3lib_rr_arb_lock (NUM_REQ=4, DWIDTH=8, MAX_BEATS=4).
// Latency : inputs are driven 2 time units after each rising edge and sampled 1 unit later.
// Backpress: out_rdy is driven per scenario to exercise stalls.
module tb_c3lib_rr_arb_lock;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  gnt;
    logic        out_vld;
    logic [7:0]  out_data;
    logic        out_last;
    logic        out_rdy;
    logic [1:0]  owner_idx;
    logic        busy;
    logic        any_req;

    int checks;
    int failures;

    c3lib_rr_arb_lock #(
        .NUM_REQ  (4),
        .DWIDTH   (8),
        .MAX_BEATS(4),
        .IDXW     (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .req_last (req_last),
        .gnt      (gnt),
        .out_vld  (out_vld),
        .out_data (out_data),
        .out_last (out_last),
        .out_rdy  (out_rdy),
        .owner_idx(owner_idx),
        .busy     (busy),
        .any_req  (any_req)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to 2 units after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Clean start for each scenario: idle inputs, one reset cycle, rr_ptr=0.
    task automatic do_reset();
        req      = 4'b0000;
        req_last = 4'b0000;
        req_data = 32'h0;
        out_rdy  = 1'b1;
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
    endtask

    task automatic test_reset();
        req      = 4'b1111;
        req_last = 4'b1111;
        req_data = 32'h13121110;
        out_rdy  = 1'b1;
        rst      = 1'b1;
        #3;
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL rst_init_gnt got=%b exp=0000", gnt); end
        checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL rst_init_vld got=%b exp=0", out_vld); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_init_busy got=%b exp=0", busy); end
        checks++; if (owner_idx !== 2'd0) begin failures++; $display("FAIL rst_init_owner got=%0d exp=0", owner_idx); end
        checks++; if (any_req !== 1'b1) begin failures++; $display("FAIL rst_init_anyreq got=%b exp=1", any_req); end
        tick();
        rst = 1'b0;
        tick();
        // Owner 0 is now active and being granted.
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL rst_pre_gnt got=%b exp=0001", gnt); end
        rst = 1'b1;
        #1;
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL rst_mid_gnt got=%b exp=0000", gnt); end
        checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL rst_mid_vld got=%b exp=0", out_vld); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        checks++; if (owner_idx !== 2'd0) begin failures++; $display("FAIL rst_mid_owner got=%0d exp=0", owner_idx); end
        checks++; if (any_req !== 1'b1) begin failures++; $display("FAIL rst_mid_anyreq got=%b exp=1", any_req); end
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_hold_busy got=%b exp=0", busy); end
        checks++; if (any_req !== 1'b1) begin failures++; $display("FAIL rst_hold_anyreq got=%b exp=1", any_req); end
        req = 4'b0000;
        #1;
        checks++; if (any_req !== 1'b0) begin failures++; $display("FAIL rst_anyreq_low got=%b exp=0", any_req); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        req      = 4'b0100;
        req_data = 32'h00A50000;
        req_last = 4'b0100;
        out_rdy  = 1'b1;
        #1;
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL single_idle_gnt got=%b exp=0000", gnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
        tick();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
        checks++; if (owner_idx !== 2'd2) begin failures++; $display("FAIL single_owner got=%0d exp=2", owner_idx); end
        checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL single_gnt got=%b exp=0100", gnt); end
        checks++; if (out_data !== 8'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", out_data); end
        checks++; if (out_last !== 1'b1) begin failures++; $display("FAIL single_last got=%b exp=1", out_last); end
        tick();
        req = 4'b0000;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_release_busy got=%b exp=0", busy); end
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL single_release_gnt got=%b exp=0000", gnt); end
        checks++; if (dut.r_rr_ptr !== 2'd3) begin failures++; $display("FAIL single_rr_ptr got=%0d exp=3", dut.r_rr_ptr); end
    endtask

    task automatic test_fairness();
        logic [1:0] exp_owner [8];
        logic [3:0] exp_gnt;
        exp_owner = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        do_reset();
        req      = 4'b1111;
        req_last = 4'b1111;
        req_data = 32'h33221100;
        out_rdy  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++; if (busy !== 1'b0 || gnt !== 4'b0000) begin failures++; $display("FAIL rr_idle[%0d] got busy=%b gnt=%b exp busy=0 gnt=0000", i, busy, gnt); end
            tick();
            exp_gnt = 4'b0001 << exp_owner[i];
            checks++; if (owner_idx !== exp_owner[i]) begin failures++; $display("FAIL rr_owner[%0d] got=%0d exp=%0d", i, owner_idx, exp_owner[i]); end
            checks++; if (gnt !== exp_gnt) begin failures++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", i, gnt, exp_gnt); end
            tick();
        end
        req = 4'b0000;
    endtask

    task automatic test_burst_lock();
        do_reset();
        // One beat from requester 0 moves rr_ptr to 1.
        req      = 4'b0001;
        req_last = 4'b0001;
        req_data = 32'h000000C0;
        tick();
        tick();
        req      = 4'b0011;
        req_last = 4'b0001;
        req_data = 32'h0000B1C0;
        out_rdy  = 1'b1;
        tick();
        checks++; if (owner_idx !== 2'd1) begin failures++; $display("FAIL lock_owner got=%0d exp=1", owner_idx); end
        checks++; if (gnt !== 4'b0010 || out_data !== 8'hB1) begin failures++; $display("FAIL lock_beat1 got gnt=%b data=%h exp gnt=0010 data=b1", gnt, out_data); end
        tick();
        req_data = 32'h0000B2C0;
        out_rdy  = 1'b0;
        #1;
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL lock_stall_gnt got=%b exp=0000", gnt); end
        checks++; if (out_vld !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL lock_stall_vld got vld=%b busy=%b exp 1 1", out_vld, busy); end
        tick();
        out_rdy = 1'b1;
        #1;
        checks++; if (gnt !== 4'b0010 || out_data !== 8'hB2) begin failures++; $display("FAIL lock_beat2 got gnt=%b data=%h exp gnt=0010 data=b2", gnt, out_data); end
        checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL lock_beat2_last got=%b exp=0", out_last); end
        tick();
        req_data = 32'h0000B3C0;
        req_last = 4'b0011;
        #1;
        checks++; if (gnt !== 4'b0010 || out_last !== 1'b1) begin failures++; $display("FAIL lock_beat3 got gnt=%b last=%b exp gnt=0010 last=1", gnt, out_last); end
        tick();
        req = 4'b0001;
        #1;
        checks++; if (busy !== 1'b0 || gnt !== 4'b0000) begin failures++; $display("FAIL lock_release got busy=%b gnt=%b exp busy=0 gnt=0000", busy, gnt); end
        tick();
        checks++; if (owner_idx !== 2'd0 || gnt !== 4'b0001) begin failures++; $display("FAIL lock_next_owner got owner=%0d gnt=%b exp owner=0 gnt=0001", owner_idx, gnt); end
        tick();
        req = 4'b0000;
    endtask

    task automatic test_forced_release();
        do_reset();
        req      = 4'b1000;
        req_last = 4'b0010;
        req_data = 32'h3000_1000;
        out_rdy  = 1'b1;
        tick();
        req = 4'b1010;
        for (int b = 1; b <= 4; b++) begin
            #1;
            checks++; if (owner_idx !== 2'd3 || gnt !== 4'b1000 || busy !== 1'b1) begin failures++; $display("FAIL force_beat[%0d] got owner=%0d gnt=%b busy=%b exp owner=3 gnt=1000 busy=1", b, owner_idx, gnt, busy); end
            tick();
        end
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL force_release_busy got=%b exp=0", busy); end
        checks++; if (dut.r_rr_ptr !== 2'd0) begin failures++; $display("FAIL force_rr_ptr got=%0d exp=0", dut.r_rr_ptr); end
        tick();
        checks++; if (owner_idx !== 2'd1 || gnt !== 4'b0010) begin failures++; $display("FAIL force_next_owner got owner=%0d gnt=%b exp owner=1 gnt=0010", owner_idx, gnt); end
        tick();
        req = 4'b0000;
    endtask

    task automatic test_drop_and_reset();
        do_reset();
        req      = 4'b0001;
        req_last = 4'b0000;
        req_data = 32'h00D0_0000;
        out_rdy  = 1'b1;
        tick();
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL drop_first_gnt got=%b exp=0001", gnt); end
        tick();
        req = 4'b0100;
        #1;
        checks++; if (out_vld !== 1'b0 || busy !== 1'b1 || gnt !== 4'b0000) begin failures++; $display("FAIL drop_hold got vld=%b busy=%b gnt=%b exp vld=0 busy=1 gnt=0000", out_vld, busy, gnt); end
        tick();
        checks++; if (out_vld !== 1'b0 || busy !== 1'b1 || gnt !== 4'b0000 || owner_idx !== 2'd0) begin failures++; $display("FAIL drop_hold2 got vld=%b busy=%b gnt=%b owner=%0d exp 0 1 0000 0", out_vld, busy, gnt, owner_idx); end
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || out_vld !== 1'b0) begin failures++; $display("FAIL drop_rst got busy=%b vld=%b exp 0 0", busy, out_vld); end
        tick();
        rst = 1'b0;
        #1;
        checks++; if (dut.r_rr_ptr !== 2'd0) begin failures++; $display("FAIL drop_rst_ptr got=%0d exp=0", dut.r_rr_ptr); end
        tick();
        checks++; if (owner_idx !== 2'd2 || gnt !== 4'b0100 || busy !== 1'b1) begin failures++; $display("FAIL drop_regrant got owner=%0d gnt=%b busy=%b exp owner=2 gnt=0100 busy=1", owner_idx, gnt, busy); end
        tick();
        req = 4'b0000;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        req      = 4'b0000;
        req_last = 4'b0000;
        req_data = 32'h0;
        out_rdy  = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_burst_lock();
        test_forced_release();
        test_drop_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/c3lib_rr_arb_lock.md
Name: c3lib_rr_arb_lock

Overview:
- Round-robin arbiter with burst lock. Shares one valid/ready output channel among NUM_REQ requesters.
- Replaces ad-hoc wire-OR merging of request/data lines in c3lib sideband and control paths. Exactly one requester owns the channel at a time.
- The owner holds the channel until it sends a beat with last=1 or reaches MAX_BEATS.
- Provides an OR-reduced any-request flag for clock-gating and power control logic.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DWIDTH, 8, data width per requester.
- MAX_BEATS, 16, maximum accepted beats per ownership before forced release (1..255).
- IDXW, 2, width of the owner index; must be at least clog2(NUM_REQ).

Ports:
- clk  input  1  block clock.
- rst  input  1  asynchronous reset, active-high.
- req  input  NUM_REQ  per-requester valid.
- req_data  input  NUM_REQ*DWIDTH  per-requester data; requester i occupies bits [i*DWIDTH +: DWIDTH].
- req_last  input  NUM_REQ  per-requester end-of-burst flag.
- gnt  output  NUM_REQ  per-requester accept; beat consumed this cycle.
- out_vld  output  1  merged channel valid.
- out_data  output  DWIDTH  merged channel data.
- out_last  output  1  merged channel last.
- out_rdy  input  1  downstream ready.
- owner_idx  output  IDXW  current owner index (registered).
- busy  output  1  channel owned (registered).
- any_req  output  1  OR of all req bits (combinational).

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; owner_idx=0; rr_ptr=0; beat_cnt=0; busy=0.
  - gnt=0, out_vld=0, out_data=0, out_last=0 while in reset and in IDLE.
- State IDLE:
  - If any_req=1, pick the first set req bit scanning upward from rr_ptr, wrapping at NUM_REQ-1 to 0.
  - Next cycle: owner_idx=winner, busy=1, state BUSY, beat_cnt=0.
  - Arbitration latency is 1 cycle. No beat is accepted in IDLE.
- State BUSY (combinational datapath from owner):
  - out_vld = req[owner_idx].
  - out_data = req_data[owner_idx].
  - out_last = req_last[owner_idx].
  - gnt[owner_idx] = req[owner_idx] & out_rdy. All other gnt bits = 0.
- Each accepted beat (gnt high) increments beat_cnt (8-bit, saturating at MAX_BEATS).
- Release occurs on an accepted beat with out_last=1, or on the accepted beat that brings beat_cnt to MAX_BEATS. On release:
  - Next cycle state IDLE, busy=0.
  - rr_ptr = owner_idx+1, wrapping from NUM_REQ-1 to 0.
- Owner lock:
  - If req[owner_idx] drops mid-burst, the channel stays BUSY with out_vld=0. Other requesters are not served.
  - Requesters must keep req, data and last stable until their gnt is seen.
- Back-to-back ownership: at least one IDLE cycle between owners. Effective throughput is burst/(burst+1).
- Same requester winning again:
  - It can win again only if no other req is set when scanning from rr_ptr.
  - A single active requester therefore re-wins after one IDLE cycle.
- out_rdy=0: no gnt, beat_cnt holds, state holds. out_vld may still be 1.
- Reset mid-burst:
  - All state clears immediately; gnt and out_vld fall asynchronously.
  - The partial burst is abandoned; no replay.
- any_req is purely combinational and valid during reset.
- Unused owner_idx codes (NUM_REQ not a power of 2) never occur.

Test Plan:
- Reset during activity:
  - Stimulus: assert rst with req=4'b1111 and out_rdy=1.
  - Required: gnt=0, out_vld=0, busy=0, owner_idx=0.
  - Required: any_req=1 throughout reset.
- Single requester:
  - Stimulus: req[2]=1, data 0xA5, last=1, out_rdy=1.
  - Required: busy rises 1 cycle later with owner_idx=2.
  - Required: gnt[2] pulses one cycle with out_data=0xA5.
  - Required: busy falls the following cycle and rr_ptr=3.
- Round-robin fairness:
  - Stimulus: req=4'b1111 held, each beat last=1, out_rdy=1.
  - Required: grant order 0,1,2,3,0,… with one IDLE cycle between owners.
- Burst lock and backpressure:
  - Stimulus: owner 1 sends a 3-beat burst (last on beat 3) while req[0] is also set; out_rdy toggles 1,0,1,1.
  - Required: gnt[1] on cycles with out_rdy=1 only; gnt[0] stays 0.
  - Required: owner switches to 0 after the third beat.
- Forced release (MAX_BEATS=4):
  - Stimulus: req[3] streams with last=0; req[1] is pending.
  - Required: release after the 4th accepted beat; next owner is 1.
- Owner drop and reset mid-burst:
  - Stimulus: owner 0 drops req after 1 beat; req[2] is set.
  - Required: out_vld=0 and busy stays 1; no gnt[2].
  - Stimulus: then assert rst.
  - Required: IDLE; after release, req[2] is granted with owner_idx=2 scanning from rr_ptr=0.
